// File: rtl/switch_allocator_pkg.sv
// Shared router types: output-port encoding and mesh coordinates.
// The allocator consumes port_t from the route computation units.
package switch_allocator_pkg;

   localparam int MESH_X = 4;
   localparam int MESH_Y = 4;
   localparam int MESH_Z = 4;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4,
      UP    = 3'd5,
      DOWN  = 3'd6,
      DROP  = 3'd7
   } port_t;

   typedef struct packed {
      logic [$clog2(MESH_X)-1:0] x;
      logic [$clog2(MESH_Y)-1:0] y;
      logic [$clog2(MESH_Z)-1:0] z;
   } position_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
   parameter int  NUM_PORTS = 7,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] gnt
);

   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pos   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(NUM_PORTS))
            pos = pos - (IDX_W+1)'(NUM_PORTS);
         idx = pos[IDX_W-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output packet locks, round-robin between
// packets, zero-latency grants, and a saturating counter of dropped packets.
module switch_allocator
   import switch_allocator_pkg::*;
#(
   parameter int NUM_PORTS = 7,
   parameter int CNT_W     = 16
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic  [NUM_PORTS-1:0]                     req_valid,
   input  port_t [NUM_PORTS-1:0]                     req_port,
   input  logic  [NUM_PORTS-1:0]                     req_tail,
   input  logic  [NUM_PORTS-1:0]                     out_ready,
   output logic  [NUM_PORTS-1:0]                     grant,
   output logic  [NUM_PORTS-1:0]                     out_valid,
   output logic  [NUM_PORTS-1:0][$clog2(NUM_PORTS)-1:0] xbar_sel,
   output logic  [CNT_W-1:0]                         drop_count
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int SUM_W = $clog2(NUM_PORTS+1);

   logic [NUM_PORTS-1:0]                  locked;
   logic [NUM_PORTS-1:0][IDX_W-1:0]       owner;
   logic [NUM_PORTS-1:0][IDX_W-1:0]       rr_ptr;

   // Indexed [output][input]
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   cand;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   arb_gnt;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]   sel;
   logic [NUM_PORTS-1:0]                  own_oh;
   logic [NUM_PORTS-1:0]                  fire;
   logic [NUM_PORTS-1:0]                  sel_tail;
   logic [NUM_PORTS-1:0][IDX_W-1:0]       sel_idx;
   logic [SUM_W-1:0]                      drop_n;
   logic [CNT_W:0]                        drop_sum;

   function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(NUM_PORTS-1)) ? '0 : v + IDX_W'(1);
   endfunction

   // A locked output sees no arbitration; only its owner may proceed.
   always_comb begin
      cand = '0;
      for (int o = 0; o < NUM_PORTS; o++)
         for (int i = 0; i < NUM_PORTS; i++)
            cand[o][i] = req_valid[i] && (req_port[i] == port_t'(o)) && !locked[o];
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      localparam port_t OUT_PORT = port_t'(o);

      rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
         .req (cand[o]),
         .ptr (rr_ptr[o]),
         .gnt (arb_gnt[o])
      );

      a_owner_port: assert property (@(posedge clk) disable iff (!rst_n)
         locked[o] && req_valid[owner[o]] |-> req_port[owner[o]] == OUT_PORT);
      a_owner_drop: assert property (@(posedge clk) disable iff (!rst_n)
         locked[o] |-> !(req_valid[owner[o]] && req_port[owner[o]] == DROP));
   end

   always_comb begin
      sel      = '0;
      own_oh   = '0;
      fire     = '0;
      sel_tail = '0;
      sel_idx  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         own_oh            = '0;
         own_oh[owner[o]]  = 1'b1;
         sel[o]            = locked[o] ? (own_oh & req_valid) : arb_gnt[o];
         fire[o]           = rst_n && out_ready[o] && (|sel[o]);
         sel_tail[o]       = |(sel[o] & req_tail);
         for (int i = 0; i < NUM_PORTS; i++)
            if (sel[o][i]) sel_idx[o] = IDX_W'(i);
      end
   end

   // DROP traffic bypasses arbitration; only its tails are counted.
   always_comb begin
      grant    = '0;
      drop_n   = '0;
      xbar_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (rst_n && req_valid[i] && req_port[i] == DROP) begin
            grant[i] = 1'b1;
            if (req_tail[i]) drop_n = drop_n + SUM_W'(1);
         end
         for (int o = 0; o < NUM_PORTS; o++)
            if (fire[o] && sel[o][i]) grant[i] = 1'b1;
      end
      for (int o = 0; o < NUM_PORTS; o++)
         if (fire[o]) xbar_sel[o] = sel_idx[o];
      drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_n);
   end

   assign out_valid = fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked     <= '0;
         owner      <= '0;
         rr_ptr     <= '0;
         drop_count <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (fire[o]) begin
               if (!locked[o]) begin
                  if (sel_tail[o]) begin
                     rr_ptr[o] <= inc_wrap(sel_idx[o]);
                  end else begin
                     locked[o] <= 1'b1;
                     owner[o]  <= sel_idx[o];
                  end
               end else if (sel_tail[o]) begin
                  locked[o] <= 1'b0;
                  rr_ptr[o] <= inc_wrap(owner[o]);
               end
            end
         end
         drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: vector table plus lock, backpressure,
// drop-saturation and mid-packet reset sequences.
module tb_switch_allocator;
   import switch_allocator_pkg::*;

   localparam int N = 7;
   typedef logic [N-1:0][2:0] pvec_t;

   typedef struct {
      logic [N-1:0] valid;
      pvec_t        port;
      logic [N-1:0] tail;
      logic [N-1:0] rdy;
      logic [N-1:0] grant;
      logic [N-1:0] ov;
      pvec_t        xs;
      logic [15:0]  dc;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic  [N-1:0]      req_valid, req_tail, out_ready;
   port_t [N-1:0]      req_port;
   logic  [N-1:0]      grant, out_valid, grant_s, out_valid_s;
   logic  [N-1:0][2:0] xbar_sel, xbar_sel_s;
   logic  [15:0]       drop_count;
   logic  [1:0]        drop_count_s;

   int checks = 0;
   int errors = 0;

   switch_allocator #(.NUM_PORTS(N), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_port(req_port),
      .req_tail(req_tail), .out_ready(out_ready), .grant(grant),
      .out_valid(out_valid), .xbar_sel(xbar_sel), .drop_count(drop_count)
   );

   switch_allocator #(.NUM_PORTS(N), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_port(req_port),
      .req_tail(req_tail), .out_ready(out_ready), .grant(grant_s),
      .out_valid(out_valid_s), .xbar_sel(xbar_sel_s), .drop_count(drop_count_s)
   );

   function automatic pvec_t at(int i, int v);
      pvec_t p = '0;
      p[i] = 3'(v);
      return p;
   endfunction

   function automatic vec_t mk(logic [N-1:0] v, pvec_t p, logic [N-1:0] t, logic [N-1:0] r,
                               logic [N-1:0] g, logic [N-1:0] ov, pvec_t xs, logic [15:0] dc);
      vec_t x;
      x.valid = v; x.port = p; x.tail = t; x.rdy = r;
      x.grant = g; x.ov = ov; x.xs = xs; x.dc = dc;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input pvec_t p, input logic [N-1:0] t,
                        input logic [N-1:0] r);
      req_valid = v;
      for (int i = 0; i < N; i++) req_port[i] = port_t'(p[i]);
      req_tail  = t;
      out_ready = r;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      drive('0, '0, '0, '1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t  tbl [10];
   pvec_t pv2, pv0, pd, pw3;
   int    exp_s [3];
   int    exp_d [3];

   initial begin
      // Sequence of single-flit traffic from a fresh reset (all rr_ptr = 0).
      tbl[0] = mk(7'b0010010, at(1,EAST)|at(4,EAST), 7'b0010010, 7'h7F, 7'b0000010, 7'b0001000, at(3,1), 16'd0);
      tbl[1] = mk(7'b0010010, at(1,EAST)|at(4,EAST), 7'b0010010, 7'h7F, 7'b0010000, 7'b0001000, at(3,4), 16'd0);
      tbl[2] = mk(7'b0010010, at(1,EAST)|at(4,EAST), 7'b0010010, 7'h7F, 7'b0000010, 7'b0001000, at(3,1), 16'd0);
      tbl[3] = mk(7'b0010010, at(1,EAST)|at(4,EAST), 7'b0010010, 7'h7F, 7'b0010000, 7'b0001000, at(3,4), 16'd0);
      tbl[4] = mk(7'b1100101, at(0,NORTH)|at(2,DROP)|at(5,SOUTH)|at(6,LOCAL), 7'b1100101, 7'h7F,
                  7'b1100101, 7'b0000111, at(0,6)|at(1,0)|at(2,5), 16'd0);
      tbl[5] = mk(7'b0001010, at(1,EAST)|at(3,WEST), 7'b0001010, 7'b1101111, 7'b0000010, 7'b0001000, at(3,1), 16'd1);
      tbl[6] = mk(7'b0001000, at(3,WEST), 7'b0001000, 7'h7F, 7'b0001000, 7'b0010000, at(4,3), 16'd1);
      tbl[7] = mk(7'b0100001, '0, 7'b0100001, 7'h7F, 7'b0000001, 7'b0000001, at(0,0), 16'd1);
      tbl[8] = mk(7'b0100001, '0, 7'b0100001, 7'h7F, 7'b0100000, 7'b0000001, at(0,5), 16'd1);
      tbl[9] = mk(7'b0000000, '0, 7'b0000000, 7'h7F, 7'b0000000, 7'b0000000, '0, 16'd1);

      // Reset with every input requesting (DROP tails would bump the counter).
      drive('1, at(0,DROP)|at(1,EAST)|at(2,DROP)|at(3,UP)|at(4,DROP)|at(5,WEST)|at(6,DROP), '1, '1);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_xbar", xbar_sel, 0);
      chk("rst_drop", drop_count, 0);
      @(negedge clk);
      chk("rst_drop_after_edge", drop_count, 0);
      chk("rst_grant_sat", grant_s, 0);
      drive('0, '0, '0, '1);
      rst_n = 1'b1;

      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].valid, tbl[k].port, tbl[k].tail, tbl[k].rdy);
         #1;
         chk($sformatf("tbl%0d_grant", k), grant, tbl[k].grant);
         chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
         chk($sformatf("tbl%0d_drop", k), drop_count, tbl[k].dc);
         for (int o = 0; o < N; o++)
            if (tbl[k].ov[o]) chk($sformatf("tbl%0d_xbar%0d", k, o), xbar_sel[o], tbl[k].xs[o]);
         tick();
      end

      // Wormhole lock: 3-flit packet from input 2 to UP, input 0 waits.
      do_reset();
      pv2 = at(2,UP);
      pv0 = at(0,UP);
      drive(7'b0000100, pv2, 7'b0000000, 7'h7F); #1;
      chk("wh_head_grant", grant, 7'b0000100);
      chk("wh_head_ov", out_valid, 7'b0100000);
      chk("wh_head_xbar", xbar_sel[5], 2);
      tick();
      drive(7'b0000101, pv2|pv0, 7'b0000001, 7'h7F); #1;
      chk("wh_body_grant", grant, 7'b0000100);
      tick();
      drive(7'b0000101, pv2|pv0, 7'b0000101, 7'h7F); #1;
      chk("wh_tail_grant", grant, 7'b0000100);
      tick();
      drive(7'b0000001, pv0, 7'b0000001, 7'h7F); #1;
      chk("wh_next_grant", grant, 7'b0000001);
      chk("wh_next_xbar", xbar_sel[5], 0);
      tick();

      // Backpressure and owner bubble mid-packet (rr_ptr[5] is now 1).
      drive(7'b0000100, pv2, 7'b0000000, 7'h7F); #1;
      chk("bp_head_grant", grant, 7'b0000100);
      tick();
      for (int c = 0; c < 2; c++) begin
         drive(7'b0000101, pv2|pv0, 7'b0000001, 7'b1011111); #1;
         chk($sformatf("bp_stall%0d_grant", c), grant, 0);
         chk($sformatf("bp_stall%0d_ov", c), out_valid, 0);
         tick();
      end
      drive(7'b0000001, pv0, 7'b0000001, 7'h7F); #1;
      chk("bp_bubble_grant", grant, 0);
      tick();
      drive(7'b0000101, pv2|pv0, 7'b0000001, 7'h7F); #1;
      chk("bp_resume_grant", grant, 7'b0000100);
      chk("bp_resume_xbar", xbar_sel[5], 2);
      tick();
      drive(7'b0000101, pv2|pv0, 7'b0000101, 7'h7F); #1;
      chk("bp_tail_grant", grant, 7'b0000100);
      tick();
      drive(7'b0000001, pv0, 7'b0000001, 7'h7F); #1;
      chk("bp_next_grant", grant, 7'b0000001);
      tick();

      // Drop saturation: 2-bit counter reads 2,3,3; 16-bit reads 2,4,6.
      do_reset();
      pd = at(0,DROP)|at(6,DROP);
      exp_s = '{2, 3, 3};
      exp_d = '{2, 4, 6};
      for (int c = 0; c < 3; c++) begin
         drive(7'b1000001, pd, 7'b1000001, 7'h7F); #1;
         chk($sformatf("drop%0d_grant", c), grant, 7'b1000001);
         chk($sformatf("drop%0d_grant_sat", c), grant_s, 7'b1000001);
         chk($sformatf("drop%0d_ov", c), out_valid, 0);
         tick();
         chk($sformatf("drop%0d_count_sat", c), drop_count_s, exp_s[c]);
         chk($sformatf("drop%0d_count", c), drop_count, exp_d[c]);
      end
      drive(7'b0000001, pd, 7'b0000000, 7'h7F); #1;
      chk("drop_body_grant", grant, 7'b0000001);
      tick();
      chk("drop_body_count", drop_count, 6);

      // Reset mid-packet clears the WEST lock held by input 3.
      do_reset();
      pw3 = at(3,WEST);
      drive(7'b0001000, pw3, 7'b0000000, 7'h7F); #1;
      chk("mr_head_grant", grant, 7'b0001000);
      chk("mr_head_xbar", xbar_sel[4], 3);
      tick();
      drive(7'b0001010, pw3|at(1,WEST), 7'b0000000, 7'h7F); #1;
      chk("mr_locked_grant", grant, 7'b0001000);
      rst_n = 1'b0;
      #1;
      chk("mr_in_reset_grant", grant, 0);
      chk("mr_in_reset_ov", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr_after_grant", grant, 7'b0000010);
      chk("mr_after_xbar", xbar_sel[4], 1);
      tick();
      drive('0, '0, '0, '1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router output-port allocator for the 3D-mesh wormhole router. It sits downstream of the per-input route computation units and consumes their `port_t` outport decisions. Each cycle it decides which input flit crosses the crossbar to which output. Packets hold an output from head to tail, arbitration between packets is round-robin, and packets routed to `DROP` are sunk and counted.

## Interface
Parameters:
- `NUM_PORTS`, default 7: router ports, indexed by `port_t` value (LOCAL..DOWN).
- `CNT_W`, default 16: width of the drop counter.

Ports:
- `clk` input, 1: sole clock, rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `req_valid` input, [NUM_PORTS]: input i presents a flit.
- `req_port` input, port_t[NUM_PORTS]: outport computed for input i's packet. Constant from head to tail.
- `req_tail` input, [NUM_PORTS]: input i's current flit is the tail. A single-flit packet has head = tail.
- `out_ready` input, [NUM_PORTS]: downstream of output o can accept a flit this cycle (credit available).
- `grant` output, [NUM_PORTS]: input i's flit is consumed this cycle.
- `out_valid` output, [NUM_PORTS]: output o carries a flit this cycle.
- `xbar_sel` output, [NUM_PORTS][$clog2(NUM_PORTS)]: input index driving output o.
- `drop_count` output, CNT_W: saturating count of dropped packets.

## Operation
- Per-output state:
  - `locked[o]`: 1 bit.
  - `owner[o]`: input index.
  - `rr_ptr[o]`: input index.
- **IDLE output o** (`locked[o]`=0):
  - Candidates are the inputs i with `req_valid[i]` and `req_port[i]==o`.
  - The winner is the first candidate scanning i = `rr_ptr[o]`, `rr_ptr[o]`+1, … mod NUM_PORTS.
  - If a winner exists and `out_ready[o]`=1:
    - assert `grant[winner]`, `out_valid[o]`, and `xbar_sel[o]`=winner;
    - if the flit is not a tail, go to LOCKED with `owner[o]`=winner;
    - if it is a tail, stay IDLE and set `rr_ptr[o]`=(winner+1) mod NUM_PORTS.
- **LOCKED output o**:
  - Only `owner[o]` may use output o.
  - If `req_valid[owner]` and `out_ready[o]` are both 1, grant and drive the output.
  - On a granted tail, go to IDLE and set `rr_ptr[o]`=(owner+1) mod NUM_PORTS.
- **out_ready[o]=0**: no grant on output o; lock, owner and pointer are unchanged.
- **Owner bubble** (`req_valid[owner]`=0 while LOCKED): no grant, lock held. Other requesters to o wait.
- **DROP requests** (`req_port`==DROP):
  - Granted every cycle `req_valid` is high, with no arbitration and no `out_valid`.
  - `drop_count` increments by the number of inputs granted with tail on DROP this cycle, saturating at 2^CNT_W−1.
- **Protocol violations** (simulation assertions only; no RTL recovery):
  - a LOCKED owner presenting a different `req_port`;
  - `req_port`==DROP on an input that owns an output lock.
- An input receives at most one grant per cycle. Inputs ≥ NUM_PORTS do not exist.

## Timing
- `grant`, `out_valid` and `xbar_sel` are combinational from the inputs and the registered state: zero-cycle allocation latency.
- A lock takes effect the cycle after the head grant.
- A released output is arbitrated the cycle after the tail grant. A new packet can use it one cycle after release, so one idle cycle between packets on a contended output is acceptable.
- **Reset:**
  - `locked`=0, `owner`=0, `rr_ptr`=0, `drop_count`=0.
  - While `rst_n`=0, `grant`, `out_valid` and `xbar_sel` are forced to 0.
  - Reset mid-packet clears all locks immediately. Upstream input buffers are reset by the same signal.
- State updates only on `clk` rising edges where `rst_n`=1.

## Structure
- The shared package header holds:
  - `port_t`: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4, UP=5, DOWN=6, DROP=7, 3 bits;
  - `position_t` and the MESH_* dimensions.
  The allocator adds no new package types.
- One sub-module, `rr_arbiter`:
  - parameterized NUM_PORTS;
  - inputs are a request vector and a pointer; output is a one-hot grant.
  - One instance per output, in a generate loop.
- Lock and pointer registers live in `switch_allocator`.

## Test plan
- **Reset:** assert `rst_n`=0 with all `req_valid`=1 → `grant`=0, `out_valid`=0, `drop_count`=0. Release → normal arbitration from `rr_ptr`=0.
- **Round-robin:** inputs 1 and 4 both send single-flit packets to EAST(3), `out_ready`=1 for 4 cycles → grants alternate 1, 4, 1, 4, with `xbar_sel[3]` matching.
- **Wormhole lock:** input 2 sends a 3-flit packet to UP(5) while input 0 requests UP → input 2 granted on 3 consecutive cycles. Input 0 is granted on the cycle after input 2's tail.
- **Backpressure:** mid-packet, `out_ready[5]`=0 for 2 cycles → no grants for 2 cycles, lock retained, the packet resumes afterwards.
- **Drop saturation:** `CNT_W`=2, inputs 0 and 6 each send a single-flit packet to DROP every cycle for 3 cycles → `drop_count` reads 2 then 3 then 3. Both inputs are granted every cycle.
- **Reset mid-packet:** input 3 holds WEST(4) and `rst_n` pulses low → lock cleared. After release, input 1's head to WEST wins at `rr_ptr`=0.
